// File: rtl/japlak.sv
// japlak: exact 32x32 unsigned multiplier, two pipeline stages, built from four 16x16 units.
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset, clears all pipeline registers
//   in_valid  qualifies a/b this cycle
//   a, b      32-bit unsigned operands
//   out_valid y holds the product of operands accepted two edges earlier
//   y         64-bit unsigned product
module japlak (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [63:0] y
);
  logic [31:0] p1, p2, p3, p4;
  logic [31:0] r1, r2, r3, r4;
  logic        v1;
  logic [32:0] mid;
  logic [63:0] sum;
  japlak_mul16 u_ll (.x(a[15:0]),  .z(b[15:0]),  .p(p1));
  japlak_mul16 u_hl (.x(a[31:16]), .z(b[15:0]),  .p(p2));
  japlak_mul16 u_lh (.x(a[15:0]),  .z(b[31:16]), .p(p3));
  japlak_mul16 u_hh (.x(a[31:16]), .z(b[31:16]), .p(p4));
  // middle term keeps its 33rd bit so the p2+p3 carry lands at bit 48
  always_comb begin
    mid = {1'b0, r2} + {1'b0, r3};
    sum = {r4, 32'h0} + {15'h0, mid, 16'h0} + {32'h0, r1};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r1, r2, r3, r4} <= '0;
      v1 <= 1'b0;
      y <= '0;
      out_valid <= 1'b0;
    end else begin
      {r1, r2, r3, r4} <= {p1, p2, p3, p4};
      v1 <= in_valid;
      y <= sum;
      out_valid <= v1;
    end
  end
endmodule

// japlak_mul16: exact 16x16 unsigned multiplier from 16 AND-gated shifted rows.
//   x, z  16-bit unsigned operands
//   p     32-bit product
module japlak_mul16 (
  input  logic [15:0] x,
  input  logic [15:0] z,
  output logic [31:0] p
);
  logic [31:0] rows [16];
  for (genvar i = 0; i < 16; i++) begin : g_row
    assign rows[i] = {16'h0, x & {16{z[i]}}} << i;
  end
  always_comb begin
    p = '0;
    for (int k = 0; k < 16; k++) p = p + rows[k];
  end
endmodule

// File: tb/tb_japlak.sv
// tb_japlak: directed and streaming checks for the japlak pipelined multiplier.
module tb_japlak;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic [63:0] y;
  int n_chk = 0;
  int n_fail = 0;

  japlak dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
              .out_valid(out_valid), .y(y));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                    input logic [63:0] exp);
    @(negedge clk);
    a = ta; b = tb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    @(negedge clk);
    chk({tag, "_v"}, {63'h0, out_valid}, 64'h1);
    chk(tag, y, exp);
  endtask

  logic        hv [2];
  logic [63:0] hy [2];
  logic        nv;
  logic [31:0] na, nb;

  initial begin
    #3;
    chk("reset_y", y, 64'h0);
    chk("reset_v", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_v", {63'h0, out_valid}, 64'h0);

    op("ff_ff",   32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    op("msb_msb", 32'h80000000, 32'h80000000, 64'h4000000000000000);
    op("ff_one",  32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF);
    op("zero",    32'h0,        32'h0,        64'h0);
    op("mix1",    32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080);
    op("mix2",    32'hA5A5A5A5, 32'h5A5A5A5A, {32'h0, 32'hA5A5A5A5} * {32'h0, 32'h5A5A5A5A});
    op("mix3",    32'hAAAAAAAA, 32'h55555555, 64'h38E38E3871C71C72);
    op("midcar",  32'h0001FFFF, 32'hFFFF0001, 64'h0001FFFD0002FFFF);
    op("dec1",    32'd4000000000, 32'd3000000000, 64'd12000000000000000000);
    op("dec2",    32'd123456789, 32'd987654321, 64'd121932631112635269);

    // streaming: hv/hy[0] is the drive one negedge ago, [1] two ago
    hv[0] = 1'b0; hv[1] = 1'b0; hy[0] = '0; hy[1] = '0;
    for (int i = 0; i < 1002; i++) begin
      @(negedge clk);
      chk("stream_v", {63'h0, out_valid}, {63'h0, hv[1]});
      if (hv[1]) chk("stream_y", y, hy[1]);
      nv = (i < 1000) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      na = $urandom; nb = $urandom;
      if (i % 97 == 0) na = 32'hFFFFFFFF;
      if (i % 89 == 0) nb = 32'hFFFF0001;
      a = na; b = nb; in_valid = nv;
      hv[1] = hv[0]; hy[1] = hy[0];
      hv[0] = nv; hy[0] = {32'h0, na} * {32'h0, nb};
    end

    // reset with products in flight and a live result on the output
    @(negedge clk);
    a = 32'h12345678; b = 32'h9ABCDEF0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    chk("pre_rst_y", y, 64'h0B00EA4E242D2080);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y", y, 64'h0);
    chk("async_rst_v", {63'h0, out_valid}, 64'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_v", {63'h0, out_valid}, 64'h0);
    end
    op("post_rst_op", 32'h00000003, 32'h00000005, 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
